shift_arbiter: RTL and testbench
================================

SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 Parameter: RR_EN, default 1, selects arbitration policy; 1 = round-robin, 0 = fixed priority with requester 0 winning.
REQ-002 CLK  input  1  single clock; all state updates on the rising edge.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_d  input  32  requester 0 operand.
REQ-007 req0_s  input  32  requester 0 shift amount, unsigned.
REQ-008 req0_lnr  input  1  requester 0 direction; 1 = left, 0 = logical right.
REQ-009 req1_valid, req1_ready, req1_d, req1_s, req1_lnr  same widths and directions as requester 0, for requester 1.
REQ-010 rsp_valid  output  1  result available.
REQ-011 rsp_id  output  1  index of the requester that owns the result.
REQ-012 rsp_data  output  32  shifted result.
REQ-013 rsp_ready  input  1  consumer accepts the result.

Function
REQ-014 The block shall time-share one SHIFT32 instance between the two requesters using a three-state FSM: IDLE, SHIFT, RESP.
REQ-015 In IDLE, the block shall assert at most one reqN_ready, and only for the arbitration winner among the valid requesters; both readies shall be 0 in SHIFT and RESP.
REQ-016 Handshake: a request shall transfer on a rising edge where reqN_valid=1 and reqN_ready=1; on that edge the block shall latch D, S, LnR and the requester id, and move to SHIFT.
REQ-017 reqN_ready may depend combinationally on reqN_valid; requesters shall hold their inputs stable while valid=1 and ready=0.
REQ-018 In SHIFT, the latched operands shall drive SHIFT32; on the next edge, Y shall be captured into rsp_data, the latched id into rsp_id, and the FSM shall move to RESP.
REQ-019 Latency: for a request accepted at edge N, rsp_valid shall be 1 in the cycle following edge N+1.
REQ-020 In RESP, rsp_valid=1 and rsp_data/rsp_id shall be held stable until an edge with rsp_ready=1; that edge shall return the FSM to IDLE.
REQ-021 Throughput: at most one accepted operation per 3 cycles with rsp_ready tied high; no new request shall be accepted in the same cycle a response retires.
REQ-022 Round-robin (RR_EN=1): when both requesters are valid in IDLE, the requester named by the priority pointer shall win; on each grant, the pointer shall move to the non-granted requester; a lone valid requester shall always win.
REQ-023 Fixed priority (RR_EN=0): requester 0 shall always win when valid, and the pointer shall be unused.
REQ-024 Shift arithmetic: shifts shall be logical with zero fill and no rotate; S>=32 (any upper bit of S set) shall yield 0 in either direction; bits shifted past bit 31 shall be discarded.
REQ-025 rsp_valid shall be 0 in IDLE and SHIFT; rsp_data and rsp_id shall retain their last values outside RESP.

Reset
REQ-026 When RST=1 at an edge, the FSM shall go to IDLE, the priority pointer shall be set to 0, and rsp_valid, rsp_id and rsp_data shall be cleared to 0.
REQ-027 Reset mid-operation (SHIFT or RESP) shall discard the in-flight operation and produce no response for it.
REQ-028 While RST=1, both reqN_ready outputs shall be 0.

Structure
REQ-029 A shared package shift_arb_pkg shall hold the FSM state encoding (IDLE=0, SHIFT=1, RESP=2), the requester-id width (1), and the data width constant (32).
REQ-030 The block shall contain exactly one sub-module instance: SHIFT32 (ports Y, D, S, LnR), used unmodified as the shared datapath.

Verification
REQ-031 Single request: req0 D=0x18, S=3, LnR=0, rsp_ready=1 -> rsp_valid one cycle after acceptance, rsp_data=0x3, rsp_id=0.
REQ-032 Left shift and overflow: req1 D=0xFFFFFFFF, S=31, LnR=1 -> rsp_data=0x80000000, rsp_id=1; then D=0x80000000, S=1, LnR=1 -> rsp_data=0x0.
REQ-033 Large shift: D=0xFFFFFFFF, S=32 -> rsp_data=0x0 for both LnR=0 and LnR=1; with S=16, LnR=0 -> rsp_data=0x0000FFFF.
REQ-034 Contention: both requesters continuously valid, RR_EN=1 -> grants alternate 0,1,0,1 starting with 0 after reset; with RR_EN=0 -> requester 0 is granted every time.
REQ-035 Backpressure: rsp_ready held 0 for 5 cycles in RESP -> rsp_valid/rsp_data stable, both readies 0, no new acceptance; release -> IDLE on the next edge.
REQ-036 Reset in SHIFT: RST=1 for one edge after acceptance -> rsp_valid never asserts for that operation, pointer=0, and the next request completes normally.

Source files
------------

// File: rtl/shift_arb_pkg.sv
// Shared definitions for the two-requester shift arbiter.
// Holds the FSM state encoding, the requester-id and data widths, and a
// small helper that names the "other" requester for the round-robin pointer.
package shift_arb_pkg;

  localparam int DATA_W = 32;
  localparam int ID_W   = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2
  } state_t;

  // With two requesters the non-granted one is simply the complement.
  function automatic logic [ID_W-1:0] other_id(input logic [ID_W-1:0] id);
    return ~id;
  endfunction

endpackage

// File: rtl/shift_arbiter_shift32.sv
// SHIFT32: 32-bit logical barrel shifter, zero fill, no rotate.
// Ports:
//   Y   - shifted result
//   D   - operand
//   S   - unsigned shift amount; any value >= 32 yields zero
//   LnR - direction, 1 = left, 0 = logical right
module SHIFT32
  import shift_arb_pkg::*;
(
  output logic [DATA_W-1:0] Y,
  input  logic [DATA_W-1:0] D,
  input  logic [DATA_W-1:0] S,
  input  logic              LnR
);

  logic [4:0] amt;
  logic       too_big;

  // Only the low five bits select a real shift; anything above shifts every
  // bit out, so the result is forced to zero instead of wrapping the amount.
  assign amt     = S[4:0];
  assign too_big = |S[DATA_W-1:5];

  always_comb begin
    Y = '0;
    if (!too_big) begin
      Y = LnR ? (D << amt) : (D >> amt);
    end
  end

endmodule

// File: rtl/shift_arbiter.sv
// shift_arbiter: time-shares one SHIFT32 between two requesters.
// An operation is accepted in IDLE, shifted in SHIFT, and presented in RESP
// until the consumer takes it.
// Ports:
//   CLK, RST                       - clock, synchronous active-high reset
//   reqN_valid / reqN_ready        - request handshake for requester N
//   reqN_d / reqN_s / reqN_lnr     - operand, shift amount, direction (1 = left)
//   rsp_valid / rsp_ready          - response handshake
//   rsp_id / rsp_data              - owning requester and shifted result
// Parameter RR_EN: 1 = round-robin between requesters, 0 = requester 0 first.
module shift_arbiter
  import shift_arb_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_d,
  input  logic [DATA_W-1:0] req0_s,
  input  logic              req0_lnr,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_d,
  input  logic [DATA_W-1:0] req1_s,
  input  logic              req1_lnr,
  output logic              rsp_valid,
  output logic [ID_W-1:0]   rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  input  logic              rsp_ready
);

  state_t            state_q;
  logic [ID_W-1:0]   ptr_q;
  logic [DATA_W-1:0] d_q, s_q;
  logic              lnr_q;
  logic [ID_W-1:0]   id_q;
  logic              rsp_valid_q;
  logic [ID_W-1:0]   rsp_id_q;
  logic [DATA_W-1:0] rsp_data_q;

  logic              in_idle, pick1, grant0, grant1, grant_any;
  logic [DATA_W-1:0] d_d, s_d, shift_y;
  logic              lnr_d;
  logic [ID_W-1:0]   id_d;

  // Readies are combinational so a requester is accepted in the same cycle
  // it raises valid. pick1 only breaks ties when both are valid; in fixed
  // priority mode the pointer is ignored and requester 0 always wins a tie.
  assign in_idle   = (state_q == IDLE) && !RST;
  assign pick1     = RR_EN ? ptr_q[0] : 1'b0;
  assign grant0    = in_idle && req0_valid && (!req1_valid || !pick1);
  assign grant1    = in_idle && req1_valid && (!req0_valid ||  pick1);
  assign grant_any = grant0 || grant1;

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  assign d_d   = grant1 ? req1_d   : req0_d;
  assign s_d   = grant1 ? req1_s   : req0_s;
  assign lnr_d = grant1 ? req1_lnr : req0_lnr;
  assign id_d  = grant1 ? 1'b1     : 1'b0;

  SHIFT32 u_shift32 (
    .Y   (shift_y),
    .D   (d_q),
    .S   (s_q),
    .LnR (lnr_q)
  );

  // Latched operands carry no reset: they are only observed after a grant
  // has loaded them.
  always_ff @(posedge CLK) begin
    if (state_q == IDLE && grant_any) begin
      d_q   <= d_d;
      s_q   <= s_d;
      lnr_q <= lnr_d;
      id_q  <= id_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_any) begin
            if (RR_EN) ptr_q <= other_id(id_d);
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          rsp_data_q  <= shift_y;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          // Readies are low here, so retiring never overlaps a new accept.
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: a round-robin instance checked every cycle against
// a behavioural model, plus a fixed-priority instance for contention.
module tb_shift_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        r0v = 1'b0, r1v = 1'b0, rspr = 1'b1;
  logic [31:0] r0d = '0, r0s = '0, r1d = '0, r1s = '0;
  logic        r0l = 1'b0, r1l = 1'b0;
  logic        r0rdy, r1rdy, rv, rid;
  logic [31:0] rdata;

  logic        f0v = 1'b0, f1v = 1'b0;
  logic        f0rdy, f1rdy, f_rv, f_rid;
  logic [31:0] f_rdata;

  shift_arbiter #(.RR_EN(1'b1)) dut_rr (
    .CLK(clk), .RST(rst),
    .req0_valid(r0v), .req0_ready(r0rdy), .req0_d(r0d), .req0_s(r0s), .req0_lnr(r0l),
    .req1_valid(r1v), .req1_ready(r1rdy), .req1_d(r1d), .req1_s(r1s), .req1_lnr(r1l),
    .rsp_valid(rv), .rsp_id(rid), .rsp_data(rdata), .rsp_ready(rspr)
  );

  shift_arbiter #(.RR_EN(1'b0)) dut_fp (
    .CLK(clk), .RST(rst),
    .req0_valid(f0v), .req0_ready(f0rdy), .req0_d(r0d), .req0_s(r0s), .req0_lnr(r0l),
    .req1_valid(f1v), .req1_ready(f1rdy), .req1_d(r1d), .req1_s(r1s), .req1_lnr(r1l),
    .rsp_valid(f_rv), .rsp_id(f_rid), .rsp_data(f_rdata), .rsp_ready(rspr)
  );

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  bit log_en = 1'b0;
  int glog_rr[$];
  int glog_fp[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model of the round-robin instance ----------
  int          m_phase = 0;   // 0 waiting for a request, 1 computing, 2 presenting
  logic        m_ptr = 1'b0;
  logic [31:0] m_d = '0, m_s = '0;
  logic        m_l = 1'b0, m_id = 1'b0;
  logic        m_rv = 1'b0, m_rid = 1'b0;
  logic [31:0] m_rdata = '0;

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [31:0] s,
                                            input logic l);
    logic [63:0] w;
    if (s >= 32) return 32'h0;
    w = {32'h0, d};
    w = l ? (w << s) : (w >> s);
    return w[31:0];
  endfunction

  function automatic logic exp_g0();
    return !rst && m_phase == 0 && r0v && (!r1v || m_ptr == 1'b0);
  endfunction

  function automatic logic exp_g1();
    return !rst && m_phase == 0 && r1v && (!r0v || m_ptr == 1'b1);
  endfunction

  always @(posedge clk) begin : model
    logic g0, g1;
    g0 = exp_g0();
    g1 = exp_g1();
    if (rst) begin
      m_phase = 0; m_ptr = 1'b0; m_rv = 1'b0; m_rid = 1'b0; m_rdata = 32'h0;
    end else if (m_phase == 0) begin
      if (g0 || g1) begin
        m_d = g1 ? r1d : r0d; m_s = g1 ? r1s : r0s; m_l = g1 ? r1l : r0l;
        m_id = g1; m_ptr = g0; m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_rdata = ref_shift(m_d, m_s, m_l); m_rid = m_id; m_rv = 1'b1; m_phase = 2;
    end else if (rspr) begin
      m_rv = 1'b0; m_phase = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req0_ready", r0rdy, exp_g0());
      chk("req1_ready", r1rdy, exp_g1());
      chk("rsp_valid", rv, m_rv);
      chk("rsp_data", rdata, m_rdata);
      chk("rsp_id", rid, m_rid);
      if (f_rv) chk("fp rsp_id", f_rid, 1'b0);
      if (f0rdy || f1rdy) chk("fp single grant", f0rdy & f1rdy, 1'b0);
    end
    if (log_en) begin
      if (r0rdy) glog_rr.push_back(0);
      if (r1rdy) glog_rr.push_back(1);
      if (f0rdy) glog_fp.push_back(0);
      if (f1rdy) glog_fp.push_back(1);
    end
  end

  // ---------------- directed stimulus -------------------------------------
  task automatic wait_grant(input int id, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((id == 0 && r0rdy) || (id == 1 && r1rdy)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("grant timeout", (id == 0) ? r0rdy : r1rdy, 1'b1);
  endtask

  task automatic do_op(input int id, input logic [31:0] d, input logic [31:0] s,
                       input logic l, input logic [31:0] exp, input string name);
    bit ok;
    @(posedge clk); #1;
    rspr = 1'b1;
    if (id == 0) begin r0d = d; r0s = s; r0l = l; r0v = 1'b1; end
    else         begin r1d = d; r1s = s; r1l = l; r1v = 1'b1; end
    wait_grant(id, ok);
    @(posedge clk); #1;
    r0v = 1'b0; r1v = 1'b0;
    @(negedge clk);
    chk({name, " valid one cycle after accept"}, rv, 1'b0);
    @(negedge clk);
    chk({name, " valid two cycles after accept"}, rv, 1'b1);
    chk({name, " data"}, rdata, exp);
    chk({name, " id"}, rid, id[0]);
  endtask

  initial begin
    #300000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    r0v = 1'b1;                      // valid during reset must not be granted
    @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("ready held low in reset", r0rdy, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0; r0v = 1'b0;
    @(negedge clk);
    chk("reset rsp_valid", rv, 1'b0);
    chk("reset rsp_data", rdata, 32'h0);
    chk("reset rsp_id", rid, 1'b0);

    do_op(0, 32'h0000_0018, 32'd3,          1'b0, 32'h0000_0003, "single right3");
    do_op(1, 32'hFFFF_FFFF, 32'd31,         1'b1, 32'h8000_0000, "left31");
    do_op(1, 32'h8000_0000, 32'd1,          1'b1, 32'h0000_0000, "left overflow");
    do_op(0, 32'hFFFF_FFFF, 32'd32,         1'b0, 32'h0000_0000, "s32 right");
    do_op(1, 32'hFFFF_FFFF, 32'd32,         1'b1, 32'h0000_0000, "s32 left");
    do_op(0, 32'hFFFF_FFFF, 32'd16,         1'b0, 32'h0000_FFFF, "s16 right");
    do_op(1, 32'hA5A5_A5A5, 32'h8000_0001,  1'b1, 32'h0000_0000, "s msb set");
    do_op(0, 32'h1234_5678, 32'd0,          1'b1, 32'h1234_5678, "s0");
    do_op(0, 32'h0000_00F0, 32'd4,          1'b1, 32'h0000_0F00, "left4");

    // Contention from a fresh reset: both instances see both requesters.
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    r0d = 32'h100; r0s = 32'd8; r0l = 1'b0;
    r1d = 32'h1;   r1s = 32'd8; r1l = 1'b1;
    r0v = 1'b1; r1v = 1'b1; f0v = 1'b1; f1v = 1'b1; rspr = 1'b1;
    log_en = 1'b1;
    repeat (14) @(posedge clk);
    #1;
    r0v = 1'b0; r1v = 1'b0; f0v = 1'b0; f1v = 1'b0; log_en = 1'b0;
    chk("rr grant count", glog_rr.size() >= 4, 1'b1);
    chk("fp grant count", glog_fp.size() >= 4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr grant %0d", i), (glog_rr.size() > i) ? glog_rr[i] : 32'hFFFF, i % 2);
      chk($sformatf("fp grant %0d", i), (glog_fp.size() > i) ? glog_fp[i] : 32'hFFFF, 0);
    end
    repeat (4) @(posedge clk);

    // Backpressure: response held while requester 1 waits.
    #1;
    rspr = 1'b0; r0d = 32'h1234; r0s = 32'd4; r0l = 1'b1; r0v = 1'b1;
    wait_grant(0, ok);
    @(posedge clk); #1;
    r0v = 1'b0; r1d = 32'h3; r1s = 32'd1; r1l = 1'b1; r1v = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp rsp_valid", rv, 1'b1);
    chk("bp data", rdata, 32'h0001_2340);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp hold valid %0d", i), rv, 1'b1);
      chk($sformatf("bp hold data %0d", i), rdata, 32'h0001_2340);
      chk($sformatf("bp no accept %0d", i), r1rdy, 1'b0);
    end
    @(posedge clk); #1; rspr = 1'b1;
    @(negedge clk);
    chk("retire cycle no accept", r1rdy, 1'b0);
    chk("retire cycle valid", rv, 1'b1);
    @(negedge clk);
    chk("idle after release valid", rv, 1'b0);
    chk("idle after release grant", r1rdy, 1'b1);
    @(posedge clk); #1; r1v = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("bp follow-up data", rdata, 32'h0000_0006);
    chk("bp follow-up id", rid, 1'b1);

    // Reset while the accepted operation is in SHIFT.
    @(posedge clk); #1;
    r0d = 32'hF; r0s = 32'd1; r0l = 1'b1; r0v = 1'b1;
    wait_grant(0, ok);
    @(posedge clk); #1; r0v = 1'b0; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("no rsp after reset %0d", i), rv, 1'b0);
    end
    @(posedge clk); #1;
    r0d = 32'h40; r0s = 32'd2; r0l = 1'b0; r0v = 1'b1;
    r1d = 32'h7;  r1s = 32'd1; r1l = 1'b1; r1v = 1'b1;
    @(negedge clk);
    chk("pointer reset req0 wins", r0rdy, 1'b1);
    chk("pointer reset req1 waits", r1rdy, 1'b0);
    @(posedge clk); #1; r0v = 1'b0; r1v = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("post-reset op valid", rv, 1'b1);
    chk("post-reset op data", rdata, 32'h0000_0010);
    chk("post-reset op id", rid, 1'b0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
